data_cache_ctrl: RTL and testbench

Direct-mapped, write-through data cache controller sitting between the MEM stage and main memory. It services `memRead`/`memWrite` from the EX/MEM register, returns `readData` into the MEM/WB register, and drives `hit`, the pipeline-wide stall qualifier. `hit==0` freezes MEM/WB and all upstream stage registers. Misses refill a full line from main memory over a req/ready handshake.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_data_array.sv | 58 +++++
 rtl/data_cache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field geometry for the direct-mapped data cache.
package cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int WORD_LSB = 2;

   localparam int DEF_INDEX_BITS  = 4;
   localparam int DEF_OFFSET_BITS = 2;
   localparam int DEF_TAG_BITS    = ADDR_W - WORD_LSB - DEF_INDEX_BITS - DEF_OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      WDONE  = 2'd3
   } state_t;

   // Tag width left over once byte, offset and index fields are carved out.
   function automatic int tag_bits(input int index_bits, input int offset_bits);
      return ADDR_W - WORD_LSB - index_bits - offset_bits;
   endfunction

endpackage

// File: rtl/cache_data_array.sv
// Tag, valid and data storage: async read by index/offset, sync writes.
module cache_data_array
   import cache_pkg::*;
#(
   parameter int INDEX_BITS  = DEF_INDEX_BITS,
   parameter int OFFSET_BITS = DEF_OFFSET_BITS,
   parameter int TAG_BITS    = DEF_TAG_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_BITS-1:0]  index,
   input  logic [OFFSET_BITS-1:0] rd_offset,
   output logic                   rd_valid,
   output logic [TAG_BITS-1:0]    rd_tag,
   output logic [DATA_W-1:0]      rd_data,
   input  logic                   wr_en,
   input  logic [OFFSET_BITS-1:0] wr_offset,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   tag_we,
   input  logic [TAG_BITS-1:0]    tag_wdata,
   input  logic                   inv_en
);

   localparam int LINES     = 2 ** INDEX_BITS;
   localparam int WORDS_ALL = 2 ** (INDEX_BITS + OFFSET_BITS);

   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [WORDS_ALL];

   assign rd_valid = valid_q[index];
   assign rd_tag   = tag_mem[index];
   assign rd_data  = data_mem[{index, rd_offset}];

   // Valid bits: cleared when a refill starts, set when its last beat lands.
   always_comb begin
      valid_d = valid_q;
      if (inv_en) valid_d[index] = 1'b0;
      if (tag_we) valid_d[index] = 1'b1;
   end

   // Only the valid bits are reset; tags and data are don't-care while invalid.
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Tag is written together with setting the valid bit.
   always_ff @(posedge clk) begin
      if (tag_we) tag_mem[index] <= tag_wdata;
   end

   // One word per cycle, either a refill beat or a write-through hit update.
   always_ff @(posedge clk) begin
      if (wr_en) data_mem[{index, wr_offset}] <= wr_data;
   end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through data cache controller between MEM stage and memory.
module data_cache_ctrl
   import cache_pkg::*;
#(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData,
   output logic              hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
   localparam int IDX_LSB  = WORD_LSB + OFFSET_BITS;
   localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;

   state_t                 state_q, state_d;
   logic [OFFSET_BITS-1:0] cnt_q, cnt_d, cnt_inc;
   logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

   logic [ADDR_W-1:0]      lk_addr;
   logic [INDEX_BITS-1:0]  lk_index;
   logic [OFFSET_BITS-1:0] lk_offset;
   logic [TAG_BITS-1:0]    lk_tag;
   logic                   rd_valid, lookup_hit;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [DATA_W-1:0]      rd_data;
   logic                   wr_en, tag_we, inv_en;
   logic [OFFSET_BITS-1:0] wr_offset;
   logic [DATA_W-1:0]      wr_data;
   logic                   unused_byte_bits;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cnt_inc   = cnt_q + OFFSET_BITS'(1);

   // Look up the incoming address in IDLE, the latched request otherwise.
   always_comb begin
      lk_addr    = (state_q == IDLE) ? addr : req_addr_q;
      lk_index   = lk_addr[TAG_LSB-1:IDX_LSB];
      lk_offset  = lk_addr[IDX_LSB-1:WORD_LSB];
      lk_tag     = lk_addr[ADDR_W-1:TAG_LSB];
      lookup_hit = rd_valid && (rd_tag == lk_tag);
   end

   assign unused_byte_bits = ^lk_addr[WORD_LSB-1:0];

   cache_data_array #(
      .INDEX_BITS (INDEX_BITS),
      .OFFSET_BITS(OFFSET_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .index    (lk_index),
      .rd_offset(lk_offset),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_offset(wr_offset),
      .wr_data  (wr_data),
      .tag_we   (tag_we),
      .tag_wdata(lk_tag),
      .inv_en   (inv_en)
   );

   // Stall qualifier and load data: read hits complete combinationally in IDLE.
   always_comb begin
      hit      = 1'b0;
      readData = '0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (memWrite) begin
                  hit = 1'b0;
               end else if (memRead) begin
                  hit = lookup_hit;
                  if (lookup_hit) readData = rd_data;
               end else begin
                  hit = 1'b1;
               end
            end
            WDONE:   hit = 1'b1;
            default: hit = 1'b0;
         endcase
      end
   end

   // Next-state, beat counter, latched request, memory-side outputs and array writes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_addr_d  = req_addr_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_en       = 1'b0;
      wr_offset   = cnt_q;
      wr_data     = mem_rdata;
      tag_we      = 1'b0;
      inv_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (memWrite) begin
               state_d     = WRITE;
               req_addr_d  = {addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
               mem_wdata_d = writeData;
            end else if (memRead && !lookup_hit) begin
               state_d    = REFILL;
               cnt_d      = '0;
               req_addr_d = {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
               inv_en     = 1'b1;
            end
         end
         REFILL: begin
            if (mem_ready) begin
               wr_en = 1'b1;
               if (cnt_q == {OFFSET_BITS{1'b1}}) begin
                  tag_we    = 1'b1;
                  state_d   = IDLE;
                  cnt_d     = '0;
                  mem_req_d = 1'b0;
               end else begin
                  cnt_d      = cnt_inc;
                  mem_addr_d = {req_addr_q[ADDR_W-1:IDX_LSB], cnt_inc, {WORD_LSB{1'b0}}};
               end
            end
         end
         WRITE: begin
            wr_offset = lk_offset;
            wr_data   = mem_wdata_q;
            if (mem_ready) begin
               wr_en     = lookup_hit;
               state_d   = WDONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         WDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (rst) begin
         wr_en  = 1'b0;
         tag_we = 1'b0;
         inv_en = 1'b0;
      end
   end

   // Controller state; the latched request address needs no reset.
   always_ff @(posedge clk) begin
      req_addr_q <= req_addr_d;
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl with a fixed-latency memory model.
module tb_data_cache_ctrl;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite;
   logic [31:0] addr, writeData, readData;
   logic        hit;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      int          stall;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } mexp_t;

   exp_t        sb_q[$];
   mexp_t       mem_q[$];
   logic [31:0] mem_store [logic [31:0]];

   always #5 clk = ~clk;

   data_cache_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .memRead  (memRead),
      .memWrite (memWrite),
      .addr     (addr),
      .writeData(writeData),
      .readData (readData),
      .hit      (hit),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Untouched memory: line 0x10 holds 0xA0+word; other lines get a distinct pattern.
   function automatic logic [31:0] mem_default(input logic [31:0] a);
      logic [27:0] blk;
      blk = a[31:4] ^ 28'h1;
      return 32'hA0 + ({4'b0, blk} << 8) + {30'b0, a[3:2]};
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return mem_default(a);
   endfunction

   // Memory model: every request beat completes L cycles after it is presented.
   initial begin
      int    cnt;
      mexp_t e;
      cnt       = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt       = 0;
         end
         if (mem_req) begin
            cnt++;
            if (cnt >= L) begin
               mem_ready = 1'b1;
               if (mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mem_unexpected: got request addr %h we %0d, expected none", mem_addr, mem_we);
               end else begin
                  e = mem_q.pop_front();
                  chk("mem_addr", mem_addr, e.addr);
                  chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                  if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
               end
               if (mem_we) mem_store[mem_addr] = mem_wdata;
               else        mem_rdata = mem_read(mem_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: counts stall cycles and pops the scoreboard when an access completes.
   initial begin
      int   stall;
      exp_t e;
      stall = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 0;
         end else if (memRead || memWrite) begin
            if (!hit) begin
               stall++;
            end else begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got completion with readData %h, expected none", readData);
               end else begin
                  e = sb_q.pop_front();
                  chk("readData", readData, e.data);
                  chk("stall_cycles", 32'(stall), 32'(e.stall));
               end
               stall = 0;
            end
         end
      end
   end

   task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_data, input int exp_stall, input int beats);
      int   n;
      logic done;
      sb_q.push_back('{data: exp_data, stall: exp_stall});
      if (we) begin
         mem_q.push_back('{addr: a, we: 1'b1, wdata: wd});
      end else begin
         for (int k = 0; k < beats; k++)
            mem_q.push_back('{addr: {a[31:4], 4'b0} + 32'(4 * k), we: 1'b0, wdata: 32'h0});
      end
      @(posedge clk);
      #2;
      memRead   = !we;
      memWrite  = we;
      addr      = a;
      writeData = wd;
      n    = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (hit) done = 1'b1;
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL access_timeout: got no completion for addr %h in 200 cycles, expected hit", a);
      end
      @(posedge clk);
      #2;
      memRead  = 1'b0;
      memWrite = 1'b0;
   endtask

   initial begin
      int n;
      int seen;
      rst       = 1'b1;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      addr      = '0;
      writeData = '0;

      @(posedge clk);
      @(negedge clk);
      chk("rst_hit", {31'b0, hit}, 32'h0);
      chk("rst_readData", readData, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_hit", {31'b0, hit}, 32'h1);
      chk("idle_mem_req", {31'b0, mem_req}, 32'h0);
      chk("idle_mem_addr", mem_addr, 32'h0);
      chk("idle_readData", readData, 32'h0);

      do_access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_00A0, 9, 4);
      do_access(1'b0, 32'h0000_0018, 32'h0, 32'h0000_00A2, 0, 0);
      do_access(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0, 3, 0);
      do_access(1'b0, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF, 0, 0);
      do_access(1'b1, 32'h0000_1100, 32'h1234_5678, 32'h0, 3, 0);
      do_access(1'b0, 32'h0000_1100, 32'h0, 32'h1234_5678, 9, 4);
      do_access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_00A0, 0, 0);
      do_access(1'b0, 32'h0000_0110, 32'h0, 32'h0000_10A0, 9, 4);
      do_access(1'b0, 32'h0000_001C, 32'h0, 32'h0000_00A3, 9, 4);
      do_access(1'b0, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF, 0, 0);

      // Miss on 0x20, abort with reset after two beats have completed.
      mem_q.push_back('{addr: 32'h20, we: 1'b0, wdata: 32'h0});
      mem_q.push_back('{addr: 32'h24, we: 1'b0, wdata: 32'h0});
      @(posedge clk);
      #2;
      memRead = 1'b1;
      addr    = 32'h0000_0020;
      n    = 0;
      seen = 0;
      while (seen < 2 && n < 50) begin
         @(negedge clk);
         if (mem_ready) seen++;
         n++;
      end
      chk("abort_beats_seen", 32'(seen), 32'd2);
      @(posedge clk);
      #2;
      rst     = 1'b1;
      memRead = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
      chk("abort_hit", {31'b0, hit}, 32'h0);
      chk("abort_readData", readData, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      do_access(1'b0, 32'h0000_0020, 32'h0, 32'h0000_03A0, 9, 4);
      do_access(1'b0, 32'h0000_0024, 32'h0, 32'h0000_03A1, 0, 0);

      repeat (4) @(posedge clk);
      chk("sb_left", 32'(sb_q.size()), 32'd0);
      chk("mem_left", 32'(mem_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by time limit, expected completion");
      $fatal(1);
   end

endmodule
